// File: rtl/mgmt_bus_pkg.sv
// Shared widths and enums for the management register bus arbiter.
package mgmt_bus_pkg;

  localparam int MGMT_ADDR_BITS = 16;
  localparam int MGMT_DATA_BITS = 8;

  typedef enum logic {
    OP_READ  = 1'b0,
    OP_WRITE = 1'b1
  } mgmt_op_t;

  typedef enum logic [1:0] {
    ARB_IDLE,
    ARB_ISSUE,
    ARB_WAIT
  } arb_state_t;

endpackage

// File: rtl/mgmt_bus_arbiter_picker.sv
// Round-robin picker: first pending index strictly after ptr, wrapping modulo NUM_REQ.
module mgmt_rr_picker #(
  parameter int NUM_REQ = 3
) (
  input  logic [NUM_REQ-1:0]         pending,
  input  logic [$clog2(NUM_REQ)-1:0] ptr,
  output logic [NUM_REQ-1:0]         grant,
  output logic [$clog2(NUM_REQ)-1:0] grant_idx
);

  localparam int IDX_W = $clog2(NUM_REQ);

  int idx;

  // NOTE: every always_comb output gets a default first, so no path leaves it unassigned (no latch).
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    idx       = 0;
    // Scan farthest-to-nearest so the nearest pending index after ptr is written last and wins.
    for (int k = NUM_REQ; k >= 1; k--) begin
      idx = (int'(ptr) + k) % NUM_REQ;
      if (pending[IDX_W'(idx)]) begin
        grant            = '0;
        grant[IDX_W'(idx)] = 1'b1;
        grant_idx        = IDX_W'(idx);
      end
    end
  end

endmodule

// File: rtl/mgmt_bus_arbiter.sv
// Round-robin arbiter sharing the management register bus between NUM_REQ masters.
// Optional read watchdog enabled by defining MGMT_ARB_TIMEOUT_EN.
module mgmt_bus_arbiter
  import mgmt_bus_pkg::*;
#(
  parameter int NUM_REQ        = 3,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                                    clk,
  input  logic                                    rst_n,
  input  logic [NUM_REQ-1:0]                      req_rd_en,
  input  logic [NUM_REQ-1:0]                      req_wr_en,
  input  logic [NUM_REQ-1:0][MGMT_ADDR_BITS-1:0]  req_addr,
  input  logic [NUM_REQ-1:0][MGMT_DATA_BITS-1:0]  req_wr_data,
  output logic [NUM_REQ-1:0]                      req_ready,
  output logic [NUM_REQ-1:0]                      req_wr_done,
  output logic [NUM_REQ-1:0]                      req_rd_valid,
  output logic [MGMT_DATA_BITS-1:0]               req_rd_data,
  output logic [NUM_REQ-1:0]                      req_rd_err,
  output logic [NUM_REQ-1:0]                      req_err,
  output logic                                    mgmt_rd_en,
  output logic [MGMT_ADDR_BITS-1:0]               mgmt_rd_addr,
  input  logic                                    mgmt_rd_valid,
  input  logic [MGMT_DATA_BITS-1:0]               mgmt_rd_data,
  output logic                                    mgmt_wr_en,
  output logic [MGMT_ADDR_BITS-1:0]               mgmt_wr_addr,
  output logic [MGMT_DATA_BITS-1:0]               mgmt_wr_data
);

  localparam int IDX_W = $clog2(NUM_REQ);

  if (NUM_REQ < 2 || NUM_REQ > 8 || TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_param_check
    $error("mgmt_bus_arbiter: NUM_REQ or TIMEOUT_CYCLES out of range");
  end

  arb_state_t                state;
  logic [NUM_REQ-1:0]        pending;
  logic [NUM_REQ-1:0]        accept;
  logic [NUM_REQ-1:0]        grant;
  logic [IDX_W-1:0]          grant_idx;
  logic [IDX_W-1:0]          ptr;
  logic [IDX_W-1:0]          owner;
  mgmt_op_t                  cur_op;
  logic [MGMT_ADDR_BITS-1:0] cur_addr;

  mgmt_op_t                  slot_op   [NUM_REQ];
  logic [MGMT_ADDR_BITS-1:0] slot_addr [NUM_REQ];
  logic [MGMT_DATA_BITS-1:0] slot_data [NUM_REQ];

  assign accept       = ~pending & (req_rd_en | req_wr_en);
  assign req_ready    = ~pending;
  assign mgmt_rd_addr = cur_addr;
  assign mgmt_wr_addr = cur_addr;

  mgmt_rr_picker #(.NUM_REQ(NUM_REQ)) u_picker (
    .pending   (pending),
    .ptr       (ptr),
    .grant     (grant),
    .grant_idx (grant_idx)
  );

`ifdef MGMT_ARB_TIMEOUT_EN
  localparam int CNT_W = (TIMEOUT_CYCLES > 255) ? 16 : 8;
  logic [CNT_W-1:0]   wait_cnt;
  logic [NUM_REQ-1:0] rd_err_q;
  assign req_rd_err = rd_err_q;
`else
  assign req_rd_err = '0;
`endif

  // NOTE: slot payload is qualified by pending, so it carries no reset and stays plain storage.
  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_REQ; i++) begin
      if (accept[i]) begin
        // A combined rd+wr strobe is taken as the write.
        slot_op[i]   <= req_wr_en[i] ? OP_WRITE : OP_READ;
        slot_addr[i] <= req_addr[i];
        slot_data[i] <= req_wr_data[i];
      end
    end
  end

  // NOTE: all sequential state uses non-blocking assignments so every register sees pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state        <= ARB_IDLE;
      pending      <= '0;
      ptr          <= IDX_W'(NUM_REQ - 1);
      owner        <= '0;
      cur_op       <= OP_READ;
      cur_addr     <= '0;
      mgmt_wr_data <= '0;
      mgmt_rd_en   <= 1'b0;
      mgmt_wr_en   <= 1'b0;
      req_wr_done  <= '0;
      req_rd_valid <= '0;
      req_rd_data  <= '0;
      req_err      <= '0;
`ifdef MGMT_ARB_TIMEOUT_EN
      wait_cnt     <= '0;
      rd_err_q     <= '0;
`endif
    end else begin
      mgmt_rd_en   <= 1'b0;
      mgmt_wr_en   <= 1'b0;
      req_wr_done  <= '0;
      req_rd_valid <= '0;
      pending      <= pending | accept;
      req_err      <= accept & req_rd_en & req_wr_en;
`ifdef MGMT_ARB_TIMEOUT_EN
      rd_err_q     <= '0;
`endif
      case (state)
        ARB_IDLE: begin
          if (|pending) begin
            ptr          <= grant_idx;
            owner        <= grant_idx;
            cur_op       <= slot_op[grant_idx];
            cur_addr     <= slot_addr[grant_idx];
            mgmt_wr_data <= slot_data[grant_idx];
            state        <= ARB_ISSUE;
            if (slot_op[grant_idx] == OP_WRITE) begin
              // Freeing the slot now makes ready rise together with the done pulse.
              mgmt_wr_en           <= 1'b1;
              req_wr_done          <= grant;
              pending[grant_idx]   <= 1'b0;
            end else begin
              mgmt_rd_en <= 1'b1;
            end
          end
        end
        ARB_ISSUE: begin
          state <= (cur_op == OP_READ) ? ARB_WAIT : ARB_IDLE;
`ifdef MGMT_ARB_TIMEOUT_EN
          wait_cnt <= '0;
`endif
        end
        ARB_WAIT: begin
          if (mgmt_rd_valid) begin
            req_rd_valid[owner] <= 1'b1;
            req_rd_data         <= mgmt_rd_data;
            pending[owner]      <= 1'b0;
            state               <= ARB_IDLE;
`ifdef MGMT_ARB_TIMEOUT_EN
          end else if (wait_cnt == CNT_W'(TIMEOUT_CYCLES)) begin
            req_rd_valid[owner] <= 1'b1;
            rd_err_q[owner]     <= 1'b1;
            req_rd_data         <= 8'hFF;
            pending[owner]      <= 1'b0;
            state               <= ARB_IDLE;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
`endif
          end
        end
        default: state <= ARB_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mgmt_bus_arbiter.sv
// Self-checking bench for mgmt_bus_arbiter: directed scenarios plus randomized traffic vs a reference model.
module tb_mgmt_bus_arbiter;
  import mgmt_bus_pkg::*;

  localparam int N = 3;
`ifdef MGMT_ARB_TIMEOUT_EN
  localparam int TO = 16;
`else
  localparam int TO = 255;
`endif

  logic                clk = 1'b0;
  logic                rst_n = 1'b0;
  logic [N-1:0]        req_rd_en = '0;
  logic [N-1:0]        req_wr_en = '0;
  logic [N-1:0][15:0]  req_addr = '0;
  logic [N-1:0][7:0]   req_wr_data = '0;
  logic [N-1:0]        req_ready, req_wr_done, req_rd_valid, req_rd_err, req_err;
  logic [7:0]          req_rd_data;
  logic                mgmt_rd_en, mgmt_wr_en;
  logic [15:0]         mgmt_rd_addr, mgmt_wr_addr;
  logic                mgmt_rd_valid = 1'b0;
  logic [7:0]          mgmt_rd_data = '0;
  logic [7:0]          mgmt_wr_data;

  always #5 clk = ~clk;

  mgmt_bus_arbiter #(.NUM_REQ(N), .TIMEOUT_CYCLES(TO)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .req_rd_en     (req_rd_en),
    .req_wr_en     (req_wr_en),
    .req_addr      (req_addr),
    .req_wr_data   (req_wr_data),
    .req_ready     (req_ready),
    .req_wr_done   (req_wr_done),
    .req_rd_valid  (req_rd_valid),
    .req_rd_data   (req_rd_data),
    .req_rd_err    (req_rd_err),
    .req_err       (req_err),
    .mgmt_rd_en    (mgmt_rd_en),
    .mgmt_rd_addr  (mgmt_rd_addr),
    .mgmt_rd_valid (mgmt_rd_valid),
    .mgmt_rd_data  (mgmt_rd_data),
    .mgmt_wr_en    (mgmt_wr_en),
    .mgmt_wr_addr  (mgmt_wr_addr),
    .mgmt_wr_data  (mgmt_wr_data)
  );

  int n_checks = 0;
  int n_fail   = 0;
  bit chk_en   = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: per-master request table, a "last winner" pointer, and the bus in one of
  // three conditions (free, strobing this cycle, awaiting read data).
  bit          m_pend [N];
  bit          m_wr   [N];
  logic [15:0] m_addr [N];
  logic [7:0]  m_data [N];
  int          m_last, m_owner, m_wait;
  bit          m_strobing, m_awaiting, m_cur_wr;
  logic [N-1:0] e_wr_done, e_rd_valid, e_rd_err, e_err;
  logic        e_wr_en, e_rd_en;
  logic [15:0] e_addr;
  logic [7:0]  e_wdata, e_rd_data;

  always @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < N; i++) m_pend[i] = 1'b0;
      m_last = N - 1; m_owner = 0; m_wait = 0;
      m_strobing = 1'b0; m_awaiting = 1'b0; m_cur_wr = 1'b0;
      e_wr_done = '0; e_rd_valid = '0; e_rd_err = '0; e_err = '0;
      e_wr_en = 1'b0; e_rd_en = 1'b0; e_addr = '0; e_wdata = '0; e_rd_data = '0;
    end else begin : upd
      bit was_free;
      bit old_pend [N];
      int c;
      old_pend = m_pend;
      was_free = !m_strobing && !m_awaiting;
      e_wr_done = '0; e_rd_valid = '0; e_rd_err = '0; e_err = '0;
      e_wr_en = 1'b0; e_rd_en = 1'b0;
      if (m_awaiting) begin
        if (mgmt_rd_valid) begin
          e_rd_valid[m_owner] = 1'b1; e_rd_data = mgmt_rd_data;
          m_pend[m_owner] = 1'b0; m_awaiting = 1'b0;
`ifdef MGMT_ARB_TIMEOUT_EN
        end else if (m_wait == TO) begin
          e_rd_valid[m_owner] = 1'b1; e_rd_err[m_owner] = 1'b1; e_rd_data = 8'hFF;
          m_pend[m_owner] = 1'b0; m_awaiting = 1'b0;
`endif
        end else begin
          m_wait++;
        end
      end
      if (m_strobing) begin
        m_strobing = 1'b0;
        if (!m_cur_wr) begin m_awaiting = 1'b1; m_wait = 0; end
      end
      if (was_free) begin
        for (int k = 1; k <= N; k++) begin
          c = (m_last + k) % N;
          if (old_pend[c]) begin
            m_last = c; m_owner = c; m_cur_wr = m_wr[c];
            e_addr = m_addr[c]; e_wdata = m_data[c]; m_strobing = 1'b1;
            if (m_wr[c]) begin
              e_wr_en = 1'b1; e_wr_done[c] = 1'b1; m_pend[c] = 1'b0;
            end else begin
              e_rd_en = 1'b1;
            end
            break;
          end
        end
      end
      for (int i = 0; i < N; i++) begin
        if (!old_pend[i] && (req_rd_en[i] || req_wr_en[i])) begin
          m_pend[i] = 1'b1; m_wr[i] = req_wr_en[i];
          m_addr[i] = req_addr[i]; m_data[i] = req_wr_data[i];
          e_err[i]  = req_rd_en[i] && req_wr_en[i];
        end
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin : cmp
      logic [N-1:0] e_ready;
      for (int i = 0; i < N; i++) e_ready[i] = !m_pend[i];
      check("ready",        req_ready,    e_ready);
      check("mgmt_wr_en",   mgmt_wr_en,   e_wr_en);
      check("mgmt_rd_en",   mgmt_rd_en,   e_rd_en);
      check("mgmt_rd_addr", mgmt_rd_addr, e_addr);
      check("mgmt_wr_addr", mgmt_wr_addr, e_addr);
      check("mgmt_wr_data", mgmt_wr_data, e_wdata);
      check("wr_done",      req_wr_done,  e_wr_done);
      check("rd_valid",     req_rd_valid, e_rd_valid);
      check("rd_err",       req_rd_err,   e_rd_err);
      check("req_err",      req_err,      e_err);
      if (e_rd_valid != '0) check("rd_data", req_rd_data, e_rd_data);
    end
  end

  task automatic tick();
    @(negedge clk);
    req_rd_en = '0; req_wr_en = '0; mgmt_rd_valid = 1'b0;
  endtask

  task automatic do_reset();
    tick(); rst_n = 1'b0;
    tick(); tick(); rst_n = 1'b1;
  endtask

  initial begin
    repeat (2) @(posedge clk);
    chk_en = 1'b1;
    tick();
    check("rst_ready",   req_ready,    3'b111);
    check("rst_wr_en",   mgmt_wr_en,   1'b0);
    check("rst_rd_en",   mgmt_rd_en,   1'b0);
    check("rst_addr",    mgmt_rd_addr, 16'h0000);
    check("rst_wdata",   mgmt_wr_data, 8'h00);
    check("rst_rd_valid", req_rd_valid, 3'b000);
    rst_n = 1'b1;

    // Master 1 writes 0x4002 <= 0x13.
    tick(); req_wr_en[1] = 1'b1; req_addr[1] = 16'h4002; req_wr_data[1] = 8'h13;
    tick(); check("t1_ready_low", req_ready, 3'b101);
    tick();
    check("t1_wr_en", mgmt_wr_en, 1'b1);
    check("t1_addr",  mgmt_wr_addr, 16'h4002);
    check("t1_data",  mgmt_wr_data, 8'h13);
    check("t1_done",  req_wr_done, 3'b010);
    check("t1_ready", req_ready, 3'b111);
    tick(); tick();

    // Master 0 reads 0x0000, responder answers 0xA5 three cycles after the strobe.
    tick(); req_rd_en[0] = 1'b1; req_addr[0] = 16'h0000;
    tick(); tick();
    check("t2_rd_en",   mgmt_rd_en, 1'b1);
    check("t2_addr0",   mgmt_rd_addr, 16'h0000);
    tick(); check("t2_addr1", mgmt_rd_addr, 16'h0000); check("t2_rd_en_low", mgmt_rd_en, 1'b0);
    tick(); check("t2_addr2", mgmt_rd_addr, 16'h0000);
    tick(); mgmt_rd_valid = 1'b1; mgmt_rd_data = 8'hA5;
    check("t2_no_valid_yet", req_rd_valid, 3'b000);
    tick();
    check("t2_valid", req_rd_valid, 3'b001);
    check("t2_data",  req_rd_data, 8'hA5);
    tick();

    // Simultaneous writes right after reset: 0,1,2; then 1 and 2 with pointer at 2: 1,2.
    do_reset();
    tick();
    for (int i = 0; i < N; i++) begin
      req_wr_en[i] = 1'b1; req_addr[i] = 16'h0100 + 16'(i); req_wr_data[i] = 8'h30 + 8'(i);
    end
    tick(); tick(); check("t3_g0", req_wr_done, 3'b001); check("t3_a0", mgmt_wr_addr, 16'h0100);
    tick(); check("t3_gap", mgmt_wr_en, 1'b0);
    tick(); check("t3_g1", req_wr_done, 3'b010); check("t3_a1", mgmt_wr_addr, 16'h0101);
    tick(); tick(); check("t3_g2", req_wr_done, 3'b100); check("t3_d2", mgmt_wr_data, 8'h32);
    tick(); req_wr_en = 3'b110;
    tick(); tick(); check("t3b_g1", req_wr_done, 3'b010);
    tick(); tick(); check("t3b_g2", req_wr_done, 3'b100);
    tick();

    // Master 2 asserts rd and wr together.
    tick(); req_rd_en[2] = 1'b1; req_wr_en[2] = 1'b1; req_addr[2] = 16'h0BAD; req_wr_data[2] = 8'h77;
    tick(); check("t4_err", req_err, 3'b100);
    tick(); check("t4_wr", mgmt_wr_en, 1'b1); check("t4_no_rd", mgmt_rd_en, 1'b0);
    check("t4_done", req_wr_done, 3'b100);
    tick(); tick();

    // Reset during the wait of a read; a late completion must be ignored.
    tick(); req_rd_en[1] = 1'b1; req_addr[1] = 16'h7777;
    tick(); tick(); check("t5_rd_en", mgmt_rd_en, 1'b1);
    tick(); rst_n = 1'b0;
    tick(); check("t5_ready", req_ready, 3'b111); check("t5_addr", mgmt_rd_addr, 16'h0000);
    rst_n = 1'b1; mgmt_rd_valid = 1'b1; mgmt_rd_data = 8'h11;
    tick(); check("t5_no_valid", req_rd_valid, 3'b000);
    tick(); check("t5_no_valid2", req_rd_valid, 3'b000);

`ifdef MGMT_ARB_TIMEOUT_EN
    // Read that never completes times out; a queued write is then served.
    begin : t6
      int k;
      bit seen;
      seen = 1'b0; k = 0;
      tick(); req_rd_en[0] = 1'b1; req_addr[0] = 16'h1234;
      tick(); k = 1; req_wr_en[2] = 1'b1; req_addr[2] = 16'h2222; req_wr_data[2] = 8'h5A;
      while (!seen && k < 40) begin
        tick(); k++;
        if (req_rd_valid[0]) seen = 1'b1;
      end
      check("t6_seen",  seen, 1'b1);
      check("t6_cycle", k, 20);
      check("t6_err",   req_rd_err, 3'b001);
      check("t6_data",  req_rd_data, 8'hFF);
      mgmt_rd_valid = 1'b1;
      seen = 1'b0; k = 0;
      while (!seen && k < 6) begin
        tick(); k++;
        if (mgmt_wr_en) seen = 1'b1;
      end
      check("t6_next_seen", seen, 1'b1);
      check("t6_next_addr", mgmt_wr_addr, 16'h2222);
      check("t6_next_data", mgmt_wr_data, 8'h5A);
      tick(); tick();
    end
`endif

    // Randomized traffic with a random-latency responder and spurious completions.
    for (int c = 0; c < 2000; c++) begin
      tick();
      for (int i = 0; i < N; i++) begin
        req_rd_en[i]   = ($urandom_range(0, 3) == 0);
        req_wr_en[i]   = ($urandom_range(0, 3) == 0);
        req_addr[i]    = 16'($urandom);
        req_wr_data[i] = 8'($urandom);
      end
      mgmt_rd_valid = ($urandom_range(0, 3) == 0);
      mgmt_rd_data  = 8'($urandom);
      rst_n = (c != 1000);
    end
    tick(); tick(); tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
